dir_seq_mux: RTL and testbench

Address source sequencer for the RTC address path: after reset it steps a fixed initialisation address sequence out to the bus controller, then arbitrates between NCH normal-mode address requesters. It is the parametrised, registered successor of the two-input init/normal address select, adding channel count, sequencing and a valid/ack handshake. It sits between the control FSMs that generate addresses and the bus interface that consumes `dir_out`.

---
 rtl/dir_seq_mux.sv | 155 +++++++++++++++
 tb/tb_dir_seq_mux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dir_seq_mux.sv
// dir_seq_mux: address source sequencer for the RTC address path.
// After reset it issues INI_COUNT init addresses starting at INI_BASE, then
// round-robin arbitrates between NCH normal-mode requesters. All outputs are
// registered and handed over with a valid/ack handshake.
//
// Optional feature macro: MUX_INI_REINIT_EN adds a `reinit` input that
// restarts the init sequence from IDLE.
//
// Ports:
//   clk, rst_n   clock (rising edge), async active-low reset
//   reinit       (MUX_INI_REINIT_EN only) restart init sequence, sampled in IDLE
//   req          per-channel address request, level
//   dir_normal   channel addresses, channel i at [i*LARGO +: LARGO]
//   gnt          one-hot grant, held for the transaction
//   dir_out      registered address to the bus controller
//   dir_valid    dir_out valid
//   dir_ack      consumer accepted dir_out (only while dir_valid=1)
//   en_dir       0 = init phase, 1 = normal phase
module dir_seq_mux #(
   parameter int unsigned      LARGO     = 8,
   parameter int unsigned      NCH       = 4,
   parameter logic [LARGO-1:0] INI_BASE  = '0,
   parameter int unsigned      INI_COUNT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef MUX_INI_REINIT_EN
   input  logic                  reinit,
`endif
   input  logic [NCH-1:0]        req,
   input  logic [NCH*LARGO-1:0]  dir_normal,
   output logic [NCH-1:0]        gnt,
   output logic [LARGO-1:0]      dir_out,
   output logic                  dir_valid,
   input  logic                  dir_ack,
   output logic                  en_dir
);

   localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CNT_W = LARGO + 1;
   localparam logic [CNT_W-1:0] INI_LAST = CNT_W'(INI_COUNT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCH - 1);

   typedef enum logic [1:0] {S_INI, S_IDLE, S_HOLD} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] ini_cnt, ini_cnt_nxt;
   logic [LARGO-1:0] dir_out_nxt;
   logic             dir_valid_nxt;
   logic [NCH-1:0]   gnt_nxt;
   logic             en_dir_nxt;
   logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0] gnt_idx, gnt_idx_nxt;

   logic             arb_found;
   logic [PTR_W-1:0] arb_idx;
   logic [PTR_W-1:0] cand;

   // Round-robin search: first requesting channel at or above rr_ptr, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         cand = PTR_W'((int'(rr_ptr) + i) % int'(NCH));
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INI;
         ini_cnt   <= '0;
         dir_out   <= INI_BASE;
         dir_valid <= 1'b0;
         gnt       <= '0;
         en_dir    <= 1'b0;
         rr_ptr    <= '0;
         gnt_idx   <= '0;
      end else begin
         state     <= state_nxt;
         ini_cnt   <= ini_cnt_nxt;
         dir_out   <= dir_out_nxt;
         dir_valid <= dir_valid_nxt;
         gnt       <= gnt_nxt;
         en_dir    <= en_dir_nxt;
         rr_ptr    <= rr_ptr_nxt;
         gnt_idx   <= gnt_idx_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      ini_cnt_nxt   = ini_cnt;
      dir_out_nxt   = dir_out;
      dir_valid_nxt = dir_valid;
      gnt_nxt       = gnt;
      en_dir_nxt    = en_dir;
      rr_ptr_nxt    = rr_ptr;
      gnt_idx_nxt   = gnt_idx;

      case (state)
         S_INI: begin
            if (!dir_valid) begin
               dir_valid_nxt = 1'b1;
            end else if (dir_ack) begin
               if (ini_cnt < INI_LAST) begin
                  ini_cnt_nxt = ini_cnt + 1'b1;
                  // Address wraps modulo 2^LARGO; carry is dropped.
                  dir_out_nxt = LARGO'(32'(INI_BASE) + 32'(ini_cnt) + 32'd1);
               end else begin
                  dir_valid_nxt = 1'b0;
                  en_dir_nxt    = 1'b1;
                  state_nxt     = S_IDLE;
               end
            end
         end

         S_IDLE: begin
`ifdef MUX_INI_REINIT_EN
            if (reinit) begin
               ini_cnt_nxt = '0;
               dir_out_nxt = INI_BASE;
               en_dir_nxt  = 1'b0;
               state_nxt   = S_INI;
            end else
`endif
            if (arb_found) begin
               dir_out_nxt   = dir_normal[32'(arb_idx)*LARGO +: LARGO];
               gnt_nxt       = NCH'(1) << arb_idx;
               gnt_idx_nxt   = arb_idx;
               dir_valid_nxt = 1'b1;
               state_nxt     = S_HOLD;
            end
         end

         S_HOLD: begin
            if (dir_ack) begin
               dir_valid_nxt = 1'b0;
               gnt_nxt       = '0;
               rr_ptr_nxt    = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
               state_nxt     = S_IDLE;
            end
         end

         default: state_nxt = S_INI;
      endcase
   end

endmodule

// File: tb/tb_dir_seq_mux.sv
// Self-checking bench for dir_seq_mux (LARGO=8, NCH=4, INI_BASE=FE, INI_COUNT=4).
module tb_dir_seq_mux;

   localparam int unsigned LARGO = 8;
   localparam int unsigned NCH   = 4;

   logic                 clk;
   logic                 rst_n;
   logic                 reinit;
   logic [NCH-1:0]       req;
   logic [NCH*LARGO-1:0] dir_normal;
   logic [NCH-1:0]       gnt;
   logic [LARGO-1:0]     dir_out;
   logic                 dir_valid;
   logic                 dir_ack;
   logic                 en_dir;

   int total = 0;
   int bad   = 0;
   int popped;

   // Expected transaction: {en_dir, gnt, dir_out}
   logic [12:0] exp_q[$];

   dir_seq_mux #(
      .LARGO(LARGO), .NCH(NCH), .INI_BASE(8'hFE), .INI_COUNT(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef MUX_INI_REINIT_EN
      .reinit(reinit),
`endif
      .req(req),
      .dir_normal(dir_normal),
      .gnt(gnt),
      .dir_out(dir_out),
      .dir_valid(dir_valid),
      .dir_ack(dir_ack),
      .en_dir(en_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Score any transfer accepted at the coming edge, then advance one cycle.
   task automatic tick();
      logic [12:0] e;
      popped = 0;
      if (dir_valid === 1'b1 && dir_ack === 1'b1) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_xfer", 32'({en_dir, gnt, dir_out}), 32'(e));
         end
         popped = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 4'b0000, 8'hFE});
      exp_q.push_back({1'b0, 4'b0000, 8'hFF});
      exp_q.push_back({1'b0, 4'b0000, 8'h00});
      exp_q.push_back({1'b0, 4'b0000, 8'h01});
   endtask

   initial begin
      int n;
      int last;
      rst_n      = 1'b0;
      reinit     = 1'b0;
      req        = '0;
      dir_ack    = 1'b1;
      dir_normal = {8'h44, 8'h33, 8'h22, 8'h11};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(dir_valid), 32'd0);
      chk("rst_gnt",   32'(gnt),       32'd0);
      chk("rst_en",    32'(en_dir),    32'd0);
      chk("rst_dir",   32'(dir_out),   32'hFE);

      // Init sequence with wrap, ack held high
      push_init();
      rst_n = 1'b1;
      tick();
      chk("ini_first_valid", 32'(dir_valid), 32'd1);
      drain("ini_drain", 20);
      chk("ini_end_en",    32'(en_dir),    32'd1);
      chk("ini_end_valid", 32'(dir_valid), 32'd0);
      chk("ini_end_dir",   32'(dir_out),   32'h01);

      // Round robin, all requesting, ack always 1
      req = 4'b1111;
      exp_q.push_back({1'b1, 4'b0001, 8'h11});
      exp_q.push_back({1'b1, 4'b0010, 8'h22});
      exp_q.push_back({1'b1, 4'b0100, 8'h33});
      exp_q.push_back({1'b1, 4'b1000, 8'h44});
      exp_q.push_back({1'b1, 4'b0001, 8'h11});
      n = 0;
      last = -1;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
         if (popped != 0) begin
            if (last >= 0) chk("rr_gap", 32'(n - last), 32'd2);
            last = n;
         end
      end
      chk("rr_drain", 32'(exp_q.size()), 32'd0);
      req = '0;
      tick();
      chk("rr_idle_valid", 32'(dir_valid), 32'd0);

      // HOLD on ch2: inputs change, outputs frozen until ack
      dir_ack    = 1'b0;
      dir_normal = {8'h44, 8'h55, 8'h22, 8'h11};
      req        = 4'b0100;
      tick();
      dir_normal = {8'h44, 8'hAA, 8'h22, 8'h11};
      req        = '0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_dir",   32'(dir_out),   32'h55);
         chk("hold_gnt",   32'(gnt),       32'h4);
         chk("hold_valid", 32'(dir_valid), 32'd1);
         tick();
      end
      dir_ack = 1'b1;
      exp_q.push_back({1'b1, 4'b0100, 8'h55});
      tick();
      chk("hold_pop",      32'(popped),    32'd1);
      chk("hold_rel_valid", 32'(dir_valid), 32'd0);
      chk("hold_rel_gnt",   32'(gnt),       32'd0);

      // Reset during HOLD (rr pointer at 3, ch0 requests)
      dir_ack = 1'b0;
      req     = 4'b0001;
      tick();
      chk("pre_rst_gnt", 32'(gnt), 32'h1);
      chk("pre_rst_dir", 32'(dir_out), 32'h11);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(dir_valid), 32'd0);
      chk("mid_rst_gnt",   32'(gnt),       32'd0);
      chk("mid_rst_en",    32'(en_dir),    32'd0);
      chk("mid_rst_dir",   32'(dir_out),   32'hFE);
      req     = '0;
      dir_ack = 1'b1;
      @(posedge clk);
      #1;
      push_init();
      rst_n = 1'b1;
      drain("reini_drain", 20);
      chk("reini_en", 32'(en_dir), 32'd1);

`ifdef MUX_INI_REINIT_EN
      // reinit has priority over req in IDLE
      reinit = 1'b1;
      req    = 4'b0001;
      push_init();
      tick();
      reinit = 1'b0;
      chk("reinit_en0", 32'(en_dir), 32'd0);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         chk("reinit_gnt0", 32'(gnt), 32'd0);
         tick();
         n++;
      end
      chk("reinit_drain", 32'(exp_q.size()), 32'd0);
      chk("reinit_en1", 32'(en_dir), 32'd1);
      exp_q.push_back({1'b1, 4'b0001, 8'h11});
      drain("reinit_grant", 10);
      req = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
